mul_share_sched: RTL and testbench



---
 rtl/mul_share_sched_pkg.sv | 13 +
 rtl/rr_arb2.sv | 38 +++
 rtl/wallace_mult.sv | 70 +++++++
 rtl/mul_share_sched.sv | 131 +++++++++++++
 tb/tb_mul_share_sched.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_share_sched_pkg.sv
// Shared definitions for the two-port multiplier scheduler: op encoding and port count.
package mul_share_sched_pkg;

    localparam int unsigned NPORTS = 2;

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULH   = 2'd1,
        OP_MULHSU = 2'd2,
        OP_MULHU  = 2'd3
    } mul_op_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-granted pointer moves only on an accept strobe.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic       gnt_vld_c,
    output logic       gnt_idx_c
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_vld_c = |req_i;
        gnt_idx_c = 1'b0;
        last_d    = last_q;
        unique case (req_i)
            2'b01:   gnt_idx_c = 1'b0;
            2'b10:   gnt_idx_c = 1'b1;
            2'b11:   gnt_idx_c = ~last_q;
            default: gnt_idx_c = 1'b0;
        endcase
        if (accept_i) begin
            last_d = gnt_idx_c;
        end
    end

    // Reset to "port 1 last" so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/wallace_mult.sv
// Combinational WxW multiplier: partial products reduced by 3:2 carry-save levels, then one final add.
// Each operand is optionally treated as signed; the 2W-bit product is exact modulo 2^(2W).
module wallace_mult #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    input  logic           sext_a_i,
    input  logic           sext_b_i,
    output logic [2*W-1:0] product_c
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned NR = W + 2;
    localparam int unsigned NA = NR + 2;

    logic [PW-1:0] a_ext;
    logic          b_neg;
    logic [PW-1:0] rows [NA];
    logic [PW-1:0] nxt  [NA];
    int            n_rows;
    int            m_rows;

    assign a_ext = sext_a_i ? {{W{a_i[W-1]}}, a_i} : {{W{1'b0}}, a_i};
    assign b_neg = sext_b_i & b_i[W-1];

    // A signed B contributes -a_ext * 2^W, added as the inverted row plus a +1 at bit W.
    always_comb begin
        for (int r = 0; r < int'(NA); r++) begin
            rows[r] = '0;
            nxt[r]  = '0;
        end
        for (int r = 0; r < int'(W); r++) begin
            rows[r] = b_i[r] ? (a_ext << r) : '0;
        end
        rows[W]   = b_neg ? (~a_ext << W) : '0;
        rows[W+1] = b_neg ? (PW'(1) << W) : '0;
        n_rows = int'(NR);
        m_rows = 0;
        for (int lvl = 0; lvl < int'(NR); lvl++) begin
            if (n_rows > 2) begin
                for (int r = 0; r < int'(NA); r++) begin
                    nxt[r] = '0;
                end
                m_rows = 0;
                for (int g = 0; g < int'(NR); g += 3) begin
                    if (g + 2 < n_rows) begin
                        nxt[m_rows]     = rows[g] ^ rows[g+1] ^ rows[g+2];
                        nxt[m_rows + 1] = ((rows[g] & rows[g+1]) | (rows[g] & rows[g+2]) |
                                           (rows[g+1] & rows[g+2])) << 1;
                        m_rows = m_rows + 2;
                    end else if (g < n_rows) begin
                        nxt[m_rows] = rows[g];
                        m_rows = m_rows + 1;
                        if (g + 1 < n_rows) begin
                            nxt[m_rows] = rows[g+1];
                            m_rows = m_rows + 1;
                        end
                    end
                end
                for (int r = 0; r < int'(NA); r++) begin
                    rows[r] = nxt[r];
                end
                n_rows = m_rows;
            end
        end
        product_c = rows[0] + rows[1];
    end

endmodule

// File: rtl/mul_share_sched.sv
// Shares one multiplier between two requesters: round-robin accept into an operand stage,
// multiply from the operand registers, register the selected product half for in-order return.
module mul_share_sched
    import mul_share_sched_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NPORTS-1:0]     req_valid,
    output logic [NPORTS-1:0]     req_ready,
    input  logic [2*NPORTS-1:0]   req_op,
    input  logic [NPORTS*W-1:0]   req_a,
    input  logic [NPORTS*W-1:0]   req_b,
    output logic [NPORTS-1:0]     resp_valid,
    input  logic [NPORTS-1:0]     resp_ready,
    output logic [W-1:0]          resp_data
);

    logic          run_q;
    logic          s1_valid_q, s1_valid_d;
    logic          s1_owner_q, s1_owner_d;
    mul_op_e       s1_op_q,    s1_op_d;
    logic [W-1:0]  s1_a_q,     s1_a_d;
    logic [W-1:0]  s1_b_q,     s1_b_d;
    logic          s2_valid_q, s2_valid_d;
    logic          s2_owner_q, s2_owner_d;
    logic [W-1:0]  s2_data_q,  s2_data_d;

    logic          drain;
    logic          s2_free;
    logic          advance;
    logic          s1_free;
    logic          accept;
    logic          gnt_vld;
    logic          gnt_idx;
    logic          sext_a;
    logic          sext_b;
    logic [2*W-1:0] product;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_valid),
        .accept_i  (accept),
        .gnt_vld_c (gnt_vld),
        .gnt_idx_c (gnt_idx)
    );

    wallace_mult #(.W(W)) u_mult (
        .a_i       (s1_a_q),
        .b_i       (s1_b_q),
        .sext_a_i  (sext_a),
        .sext_b_i  (sext_b),
        .product_c (product)
    );

    // Pipe control, accept, and stage next-state.
    always_comb begin
        drain   = s2_valid_q & resp_ready[s2_owner_q];
        s2_free = ~s2_valid_q | drain;
        advance = s1_valid_q & s2_free;
        s1_free = ~s1_valid_q | advance;

        req_ready = '0;
        if (run_q && s1_free && gnt_vld) begin
            req_ready[gnt_idx] = 1'b1;
        end
        accept = |(req_valid & req_ready);

        sext_a = (s1_op_q == OP_MULH) || (s1_op_q == OP_MULHSU);
        sext_b = (s1_op_q == OP_MULH);

        s1_valid_d = s1_valid_q;
        s1_owner_d = s1_owner_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_owner_d = gnt_idx;
            s1_op_d    = mul_op_e'(gnt_idx ? req_op[3:2] : req_op[1:0]);
            s1_a_d     = gnt_idx ? req_a[2*W-1:W] : req_a[W-1:0];
            s1_b_d     = gnt_idx ? req_b[2*W-1:W] : req_b[W-1:0];
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        s2_owner_d = s2_owner_q;
        s2_data_d  = s2_data_q;
        if (advance) begin
            s2_valid_d = 1'b1;
            s2_owner_d = s1_owner_q;
            s2_data_d  = (s1_op_q == OP_MUL) ? product[W-1:0] : product[2*W-1:W];
        end else if (drain) begin
            s2_valid_d = 1'b0;
        end

        resp_valid             = '0;
        resp_valid[s2_owner_q] = s2_valid_q;
    end

    assign resp_data = s2_data_q;

    // run_q keeps req_ready low while in reset and for the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_owner_q <= 1'b0;
            s1_op_q    <= OP_MUL;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_owner_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            run_q      <= 1'b1;
            s1_valid_q <= s1_valid_d;
            s1_owner_q <= s1_owner_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            s2_owner_q <= s2_owner_d;
            s2_data_q  <= s2_data_d;
        end
    end

endmodule

// File: tb/tb_mul_share_sched.sv
// Scoreboard bench for mul_share_sched: accepted requests push expected results, a monitor checks returns.
module tb_mul_share_sched;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } req_t;

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
        int          cyc;
        logic        lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_data;

    req_t pq0[$];
    req_t pq1[$];
    exp_t sb[$];
    int   acc_own[$];
    int   acc_cyc[$];

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [1:0] hold = 2'b00;
    logic [1:0] fired = 2'b00;
    logic       flush = 1'b0;
    logic       lat_mode = 1'b0;
    logic       rand_rr = 1'b0;
    logic [1:0] rr_fixed = 2'b11;
    int         vprob = 100;

    always #5 clk = ~clk;

    mul_share_sched #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact 66-bit signed product of the (optionally sign-extended) operands.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [65:0] ea;
        logic signed [65:0] eb;
        logic signed [65:0] p;
        ea = (op == 2'd1 || op == 2'd2) ? {{34{a[31]}}, a} : {34'd0, a};
        eb = (op == 2'd1) ? {{34{b[31]}}, b} : {34'd0, b};
        p  = ea * eb;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic enq_x(input int port, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        req_t r;
        r.op = op; r.a = a; r.b = b; r.exp = exp;
        if (port == 0) pq0.push_back(r);
        else           pq1.push_back(r);
    endtask

    task automatic enq(input int port, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
        enq_x(port, op, a, b, ref_mul(op, a, b));
    endtask

    task automatic wait_idle(input int maxc);
        int k = 0;
        while ((pq0.size() != 0 || pq1.size() != 0 || hold != 2'b00 || sb.size() != 0) && k < maxc) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        check("drain_timeout", 64'(k >= maxc), 64'd0);
    endtask

    // Request driver: holds each port's head request until it is accepted.
    initial begin
        exp_t e;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        forever begin
            @(negedge clk);
            if (flush) begin
                hold = 2'b00;
            end else begin
                if (fired[0]) begin pq0.delete(0); hold[0] = 1'b0; end
                if (fired[1]) begin pq1.delete(0); hold[1] = 1'b0; end
                if (!hold[0] && pq0.size() != 0 && int'($urandom_range(99)) < vprob) hold[0] = 1'b1;
                if (!hold[1] && pq1.size() != 0 && int'($urandom_range(99)) < vprob) hold[1] = 1'b1;
            end
            fired = 2'b00;
            req_valid     = hold;
            req_op[1:0]   = hold[0] ? pq0[0].op : 2'd0;
            req_a[31:0]   = hold[0] ? pq0[0].a  : 32'd0;
            req_b[31:0]   = hold[0] ? pq0[0].b  : 32'd0;
            req_op[3:2]   = hold[1] ? pq1[0].op : 2'd0;
            req_a[63:32]  = hold[1] ? pq1[0].a  : 32'd0;
            req_b[63:32]  = hold[1] ? pq1[0].b  : 32'd0;
            #1;
            if (rst_n) begin
                check("req_ready_at_most_one", 64'(req_ready == 2'b11), 64'd0);
                fired = req_valid & req_ready;
                for (int n = 0; n < 2; n++) begin
                    if (fired[n]) begin
                        e.owner = n[0];
                        e.data  = (n == 0) ? pq0[0].exp : pq1[0].exp;
                        e.cyc   = cyc;
                        e.lat   = lat_mode;
                        sb.push_back(e);
                        acc_own.push_back(n);
                        acc_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    // Consumer ready driver.
    initial begin
        resp_ready = 2'b11;
        forever begin
            @(negedge clk);
            resp_ready = rand_rr ? 2'($urandom_range(3)) : rr_fixed;
        end
    end

    // Response monitor: in-order scoreboard pop, owner/data/latency and stall-hold checks.
    initial begin
        logic       prev_stall = 1'b0;
        logic [1:0] pv = 2'b00;
        logic [31:0] pd = 32'd0;
        exp_t       e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (resp_valid != 2'b00) check("resp_valid_onehot", 64'(resp_valid == 2'b11), 64'd0);
            if (prev_stall) begin
                check("stall_hold_valid", 64'(resp_valid), 64'(pv));
                check("stall_hold_data", 64'(resp_data), 64'(pd));
            end
            if ((resp_valid & resp_ready) != 2'b00) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got valid=%b data=0x%0h expected no response", resp_valid, resp_data);
                end else begin
                    e = sb.pop_front();
                    check("resp_owner", 64'(resp_valid), e.owner ? 64'd2 : 64'd1);
                    check("resp_data", 64'(resp_data), 64'(e.data));
                    if (e.lat) check("latency", 64'(cyc - e.cyc), 64'd2);
                end
            end
            prev_stall = (resp_valid != 2'b00) && ((resp_valid & resp_ready) == 2'b00);
            pv = resp_valid;
            pd = resp_data;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish before 90000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with requests pending: no accept, outputs cleared.
        enq(0, 2'd0, 32'd11, 32'd13);
        enq(1, 2'd3, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (3) @(negedge clk);
        #3;
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_resp_valid", 64'(resp_valid), 64'd0);
        check("reset_resp_data", 64'(resp_data), 64'd0);
        rst_n = 1'b1;
        wait_idle(50);

        lat_mode = 1'b1;
        enq_x(0, 2'd0, 32'd7, 32'd6, 32'd42);
        wait_idle(50);

        enq_x(1, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        enq_x(1, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        enq_x(1, 2'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF);
        enq_x(1, 2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        enq_x(1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        enq_x(1, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        wait_idle(100);

        // Both ports streaming with ready consumers: alternate grants, one per cycle.
        acc_own.delete();
        acc_cyc.delete();
        for (int i = 0; i < 6; i++) begin
            enq(0, 2'($urandom_range(3)), pick32(), pick32());
            enq(1, 2'($urandom_range(3)), pick32(), pick32());
        end
        wait_idle(100);
        check("alt_count", 64'(acc_own.size()), 64'd12);
        for (int i = 1; i < acc_own.size(); i++) begin
            check("alt_owner", 64'(acc_own[i] != acc_own[i-1]), 64'd1);
            check("alt_cycle", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd1);
        end

        // Stalled consumer with both ports requesting: pipe fills and blocks.
        lat_mode = 1'b0;
        rr_fixed = 2'b00;
        for (int i = 0; i < 4; i++) begin
            enq(0, 2'($urandom_range(3)), pick32(), pick32());
            enq(1, 2'($urandom_range(3)), pick32(), pick32());
        end
        repeat (6) @(negedge clk);
        #1;
        check("stall_req_ready", 64'(req_ready), 64'd0);
        check("stall_resp_pending", 64'(resp_valid != 2'b00), 64'd1);
        rr_fixed = 2'b11;
        wait_idle(200);

        // Back-to-back on port 0: drain, advance and accept in the same cycle.
        lat_mode = 1'b1;
        enq_x(0, 2'd0, 32'd3, 32'd3, 32'd9);
        enq_x(0, 2'd0, 32'd4, 32'd4, 32'd16);
        enq_x(0, 2'd0, 32'd5, 32'd5, 32'd25);
        wait_idle(50);

        // Reset with both stages full.
        lat_mode = 1'b0;
        rr_fixed = 2'b00;
        for (int i = 0; i < 3; i++) begin
            enq(0, 2'($urandom_range(3)), pick32(), pick32());
            enq(1, 2'($urandom_range(3)), pick32(), pick32());
        end
        repeat (5) @(negedge clk);
        #3;
        check("pre_reset_full", 64'(resp_valid != 2'b00), 64'd1);
        rst_n = 1'b0;
        flush = 1'b1;
        pq0.delete();
        pq1.delete();
        sb.delete();
        #1;
        check("async_reset_resp_valid", 64'(resp_valid), 64'd0);
        check("async_reset_resp_data", 64'(resp_data), 64'd0);
        check("async_reset_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        rr_fixed = 2'b11;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            check("no_stale_resp", 64'(resp_valid), 64'd0);
        end
        acc_own.delete();
        acc_cyc.delete();
        enq(0, 2'd0, 32'd100, 32'd3);
        enq(1, 2'd0, 32'd200, 32'd3);
        wait_idle(50);
        check("tie_after_reset_count", 64'(acc_own.size()), 64'd2);
        if (acc_own.size() != 0) check("tie_after_reset_port0", 64'(acc_own[0]), 64'd0);

        // Randomized traffic and back-pressure.
        rand_rr = 1'b1;
        vprob = 60;
        for (int i = 0; i < 300; i++) begin
            enq(int'($urandom_range(1)), 2'($urandom_range(3)), pick32(), pick32());
        end
        wait_idle(20000);
        rand_rr = 1'b0;
        vprob = 100;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
